// File: rtl/multi_freq_meter.sv
// multi_freq_meter
//    Multi-channel frequency meter. Each of CH asynchronous inputs is
//    synchronised into Clk and its rising edges are counted during a gate
//    window of GATE_BASE * 10^Gate_Sel Clk cycles. At gate end all channel
//    counts are latched together and Valid pulses for one cycle.
//
// Ports
//    Clk        system clock, all logic on the rising edge
//    Rst_n      asynchronous active-low reset
//    Fxin       measured inputs (bit i = channel i), asynchronous to Clk
//    Enable     high: start/continue measuring; low: stop after current gate
//    Gate_Sel   gate length select: x1, x10, x100, x1000 of GATE_BASE
//    Frequency  latched counts, channel i at [i*WIDTH +: WIDTH]
//    Ovf        bit i set if channel i saturated during the latched gate
//    Valid      one-cycle strobe: Frequency/Ovf just updated
//    Busy       high while a measurement is in progress (state != IDLE)
module multi_freq_meter #(
   parameter int CH          = 4,
   parameter int WIDTH       = 32,
   parameter int GATE_BASE   = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [CH-1:0]       Fxin,
   input  logic                Enable,
   input  logic [1:0]          Gate_Sel,
   output logic [CH*WIDTH-1:0] Frequency,
   output logic [CH-1:0]       Ovf,
   output logic                Valid,
   output logic                Busy
);

   localparam int GW = $clog2(GATE_BASE * 1000);

   // Gate lengths are stored minus one so the longest one still fits in GW bits.
   localparam logic [GW-1:0] LEN_M1_0 = GW'(GATE_BASE - 1);
   localparam logic [GW-1:0] LEN_M1_1 = GW'(GATE_BASE * 10 - 1);
   localparam logic [GW-1:0] LEN_M1_2 = GW'(GATE_BASE * 100 - 1);
   localparam logic [GW-1:0] LEN_M1_3 = GW'(GATE_BASE * 1000 - 1);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GATE  = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [SYNC_STAGES-1:0][CH-1:0]  sync_q, sync_d;
   logic [CH-1:0]                   edge_q, edge_d;
   logic [CH-1:0]                   rise;
   logic [GW-1:0]                   gate_cnt_q, gate_cnt_d;
   logic [GW-1:0]                   len_m1_q, len_m1_d;
   logic [CH-1:0][WIDTH-1:0]        cnt_q, cnt_d;
   logic [CH-1:0]                   sat_q, sat_d;
   logic [CH-1:0][WIDTH-1:0]        freq_q, freq_d;
   logic [CH-1:0]                   ovf_q, ovf_d;
   logic                            valid_q, valid_d;

   function automatic logic [GW-1:0] len_m1_sel(input logic [1:0] sel);
      case (sel)
         2'd0:    return LEN_M1_0;
         2'd1:    return LEN_M1_1;
         2'd2:    return LEN_M1_2;
         default: return LEN_M1_3;
      endcase
   endfunction

   // Synchroniser chain plus one edge register per channel.
   always_comb begin
      sync_d[0] = Fxin;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      edge_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
   end

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      len_m1_d   = len_m1_q;
      cnt_d      = cnt_q;
      sat_d      = sat_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            gate_cnt_d = '0;
            cnt_d      = '0;
            sat_d      = '0;
            if (Enable) begin
               state_d  = S_GATE;
               len_m1_d = len_m1_sel(Gate_Sel);
            end
         end

         S_GATE: begin
            gate_cnt_d = gate_cnt_q + GW'(1);
            for (int i = 0; i < CH; i++) begin
               if (rise[i]) begin
                  // A full counter holds its value and remembers the lost edge.
                  if (cnt_q[i] == CNT_MAX) begin
                     sat_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + WIDTH'(1);
                  end
               end
            end
            if (gate_cnt_q == len_m1_q) begin
               state_d = S_LATCH;
            end
         end

         S_LATCH: begin
            // Dead cycle: publish results, discard edges, restart from zero.
            freq_d     = cnt_q;
            ovf_d      = sat_q;
            valid_d    = 1'b1;
            cnt_d      = '0;
            sat_d      = '0;
            gate_cnt_d = '0;
            if (Enable) begin
               state_d  = S_GATE;
               len_m1_d = len_m1_sel(Gate_Sel);
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         sync_q     <= '0;
         edge_q     <= '0;
         gate_cnt_q <= '0;
         len_m1_q   <= '0;
         cnt_q      <= '0;
         sat_q      <= '0;
         freq_q     <= '0;
         ovf_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         edge_q     <= edge_d;
         gate_cnt_q <= gate_cnt_d;
         len_m1_q   <= len_m1_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         freq_q     <= freq_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign Frequency = freq_q;
   assign Ovf       = ovf_q;
   assign Valid     = valid_q;
   assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_freq_meter.sv
module tb_multi_freq_meter;

   localparam int CH          = 2;
   localparam int WIDTH       = 8;
   localparam int GATE_BASE   = 100;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_MAX     = (1 << WIDTH) - 1;

   logic                Clk      = 1'b0;
   logic                Rst_n    = 1'b0;
   logic [CH-1:0]       Fxin     = '0;
   logic                Enable   = 1'b0;
   logic [1:0]          Gate_Sel = 2'd0;
   logic [CH*WIDTH-1:0] Frequency;
   logic [CH-1:0]       Ovf;
   logic                Valid;
   logic                Busy;

   multi_freq_meter #(
      .CH(CH), .WIDTH(WIDTH), .GATE_BASE(GATE_BASE), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Fxin(Fxin), .Enable(Enable), .Gate_Sel(Gate_Sel),
      .Frequency(Frequency), .Ovf(Ovf), .Valid(Valid), .Busy(Busy)
   );

   initial forever #5 Clk = ~Clk;

   // Stimulus generator state (period 0 = input held low)
   int per [CH];
   int off [CH];
   int tcnt = 0;

   // Reference record: index of the Clk edge that first sees each Fxin rise
   int            cyc = 0;
   logic [CH-1:0] fx_prev = '0;
   int            rises [CH][$];

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Square-wave drivers, changing only on the falling Clk edge
   initial forever begin
      @(negedge Clk);
      tcnt = tcnt + 1;
      for (int i = 0; i < CH; i++) begin
         Fxin[i] = (per[i] != 0) && (((tcnt + off[i]) % per[i]) < (per[i] / 2));
      end
   end

   initial forever begin
      @(posedge Clk);
      cyc = cyc + 1;
      for (int i = 0; i < CH; i++) begin
         if (Fxin[i] && !fx_prev[i]) rises[i].push_back(cyc);
      end
      fx_prev = Fxin;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_chan(input int ch, input int p);
      per[ch] = p;
      off[ch] = (p == 0) ? 0 : $urandom_range(0, p - 1);
   endtask

   function automatic int gate_len(input logic [1:0] sel);
      int l = GATE_BASE;
      for (int k = 0; k < int'(sel); k++) l = l * 10;
      return l;
   endfunction

   // An input rise first seen at edge r reaches the counter at edge r+SYNC_STAGES;
   // count those landing on edges lo..hi.
   function automatic int model_count(input int ch, input int lo, input int hi);
      int n = 0;
      foreach (rises[ch][k]) begin
         if (rises[ch][k] + SYNC_STAGES >= lo && rises[ch][k] + SYNC_STAGES <= hi) n++;
      end
      return n;
   endfunction

   // Raise Enable so that edge s samples it in IDLE; returns at the negedge after s.
   task automatic start_gate(input string tag, output int s);
      @(negedge Clk);
      Enable = 1'b1;
      s = cyc + 1;
      @(negedge Clk);
      check({tag, ".busy_rise"}, Busy, 1);
   endtask

   // Gate counting on edges s+1..s+len; Valid expected at edge s+len+1.
   task automatic run_gate(input int s, input int len, input string tag, output int nxt);
      int got = -1;
      int n;
      int lim = s + len + 8;
      while (got < 0 && cyc < lim) begin
         @(negedge Clk);
         if (Valid === 1'b1) got = cyc;
      end
      check({tag, ".valid_cycle"}, got, s + len + 1);
      for (int ch = 0; ch < CH; ch++) begin
         n = model_count(ch, s + 1, s + len);
         check($sformatf("%s.freq%0d", tag, ch), Frequency[ch*WIDTH +: WIDTH],
               (n > CNT_MAX) ? CNT_MAX : n);
         check($sformatf("%s.ovf%0d", tag, ch), Ovf[ch], (n > CNT_MAX) ? 1 : 0);
      end
      @(negedge Clk);
      check({tag, ".valid_one_cycle"}, Valid, 0);
      nxt = s + len + 1;
   endtask

   task automatic count_valids(input int ncyc, output int nv);
      nv = 0;
      repeat (ncyc) begin
         @(negedge Clk);
         if (Valid !== 1'b0) nv++;
      end
   endtask

   initial begin
      int s;
      int nv;
      int cur_len;
      logic [1:0] g;

      // Reset state
      Rst_n = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst.freq", Frequency, 0);
      check("rst.ovf", Ovf, 0);
      check("rst.valid", Valid, 0);
      check("rst.busy", Busy, 0);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);

      // Single shot, base gate, ch0 period 10
      set_chan(0, 10); set_chan(1, 0); Gate_Sel = 2'd0;
      repeat (20) @(negedge Clk);
      start_gate("t1", s);
      Enable = 1'b0;
      run_gate(s, 100, "t1", s);
      check("t1.busy_after", Busy, 0);

      // x10 gate, ch1 period 4
      set_chan(0, 0); set_chan(1, 4); Gate_Sel = 2'd1;
      repeat (10) @(negedge Clk);
      start_gate("t2", s);
      Enable = 1'b0;
      run_gate(s, 1000, "t2", s);

      // Saturation, then a quiet gate clears the flag
      set_chan(1, 0); set_chan(0, 2);
      repeat (10) @(negedge Clk);
      start_gate("t3a", s);
      Enable = 1'b0;
      run_gate(s, 1000, "t3a", s);
      set_chan(0, 0);
      repeat (5) @(negedge Clk);
      start_gate("t3b", s);
      Enable = 1'b0;
      run_gate(s, 1000, "t3b", s);

      // Continuous mode, then drop Enable mid-gate
      set_chan(0, 10); Gate_Sel = 2'd0;
      repeat (10) @(negedge Clk);
      start_gate("t4", s);
      for (int k = 0; k < 3; k++) run_gate(s, 100, $sformatf("t4.g%0d", k), s);
      Enable = 1'b0;
      run_gate(s, 100, "t4.last", s);
      check("t4.busy_after", Busy, 0);
      count_valids(150, nv);
      check("t4.no_extra_valid", nv, 0);

      // Reset in the middle of a gate
      start_gate("t5", s);
      run_gate(s, 100, "t5.g0", s);
      while (cyc < s + 50) @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      check("t5.rst_freq", Frequency, 0);
      check("t5.rst_ovf", Ovf, 0);
      check("t5.rst_valid", Valid, 0);
      check("t5.rst_busy", Busy, 0);
      Enable = 1'b0;
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      count_valids(150, nv);
      check("t5.no_valid_after_rst", nv, 0);
      start_gate("t5f", s);
      Enable = 1'b0;
      run_gate(s, 100, "t5.fresh", s);

      // Gate_Sel change mid-gate only affects the following gate
      Gate_Sel = 2'd0;
      start_gate("t6", s);
      repeat (30) @(negedge Clk);
      Gate_Sel = 2'd2;
      run_gate(s, 100, "t6.cur", s);
      Enable = 1'b0;
      run_gate(s, 10000, "t6.next", s);
      check("t6.busy_after", Busy, 0);

      // Randomised continuous run: periods and Gate_Sel change during gates
      g = 2'($urandom_range(0, 1));
      Gate_Sel = g;
      cur_len = gate_len(g);
      start_gate("t7", s);
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < CH; i++) begin
            set_chan(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 25));
         end
         g = 2'($urandom_range(0, 1));
         Gate_Sel = g;
         if (k == 5) Enable = 1'b0;
         run_gate(s, cur_len, $sformatf("t7.g%0d", k), s);
         cur_len = gate_len(g);
      end
      check("t7.busy_after", Busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/multi_freq_meter.md
# multi_freq_meter

Multi-channel, parametrised frequency meter measuring CH asynchronous input signals against one system clock. It synchronises each input, counts rising edges over a selectable gate window generated internally from Clk, and latches all channel counts together at gate end with a one-cycle Valid strobe. It supersedes the single-channel meter: width, channel count and gate length are configurable, and it adds saturation/overflow flags, single-shot and continuous modes, and a clean reset.

## Interface
- CH, 4, number of measured channels (≥1)
- WIDTH, 32, count width per channel
- GATE_BASE, 1000, base gate length in Clk cycles (≥2)
- SYNC_STAGES, 2, synchroniser flops per input (≥2)

- Clk  input  1  system clock; all logic on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- Fxin  input  CH  measured signals, asynchronous to Clk, bit i = channel i
- Enable  input  1  high: start/continue measuring; low: stop after current gate
- Gate_Sel  input  2  gate length = GATE_BASE × 10^Gate_Sel (×1, ×10, ×100, ×1000)
- Frequency  output  CH*WIDTH  latched counts; channel i at [i*WIDTH +: WIDTH]
- Ovf  output  CH  bit i set if channel i saturated during the latched gate
- Valid  output  1  one-cycle pulse: Frequency/Ovf updated
- Busy  output  1  high while state ≠ IDLE

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then one edge register; rise pulse = sync_out & ~edge_reg.
- States: IDLE, GATE, LATCH.
- IDLE: gate counter and channel counters held at 0. Enable=1 → GATE; Gate_Sel sampled into a gate-length register on this transition.
- GATE: gate counter increments each cycle; channel counter i increments on each rise pulse i. When gate counter = length−1 → LATCH (rise pulses on that last cycle are counted).
- LATCH (one cycle): Frequency ← counters, Ovf ← saturation flags, Valid ← 1 on next cycle; counters, flags, gate counter cleared. Rise pulses during LATCH are discarded. Next state GATE if Enable=1 (Gate_Sel resampled), else IDLE.
- Enable deasserted during GATE: gate completes normally, result latched, then IDLE. No abort path other than reset.
- Saturation: counter at 2^WIDTH−1 holds value; flag for that channel set, cleared only in LATCH.
- Gate counter width: $clog2(GATE_BASE*1000); length selection is a 4-way mux of constants.
- Gate_Sel changes during GATE have no effect on the running gate.

## Timing
- Reset (Rst_n=0, async): state IDLE, Frequency=0, Ovf=0, Valid=0, Busy=0, all counters, synchronisers and edge registers 0. Reset mid-gate discards the gate; no Valid for it.
- Input-to-count latency: SYNC_STAGES+1 Clk cycles from Fxin rise to counter increment; inputs must be high and low ≥1 Clk period each to be counted (Fxin ≤ Clk/2 minus margin).
- Gate window: exactly length cycles of counting, plus one dead LATCH cycle. Continuous mode: Valid period = length+1 cycles.
- Valid: high exactly one cycle, the cycle after LATCH; Frequency/Ovf stable from that cycle until next Valid.
- Busy: rises the cycle after Enable is sampled high in IDLE; falls the cycle after LATCH when returning to IDLE.
- Enable is level-sampled only in IDLE and LATCH.

## Test plan
- CH=2, WIDTH=8, GATE_BASE=100, Gate_Sel=0, Fxin[0] period 10 Clk, Enable pulsed once → one Valid, Frequency ch0 = 10, ch1 = 0, Ovf=0, Busy low after.
- Gate_Sel=1 (1000 cycles), Fxin[1] period 4 Clk → ch1 = 250, Ovf[1]=0.
- Gate_Sel=1, Fxin[0] period 2 Clk (500 edges) → ch0 = 255, Ovf[0]=1; next gate with Fxin[0] idle → ch0 = 0, Ovf[0]=0.
- Enable held high, Gate_Sel=0, Fxin[0] period 10 → Valid every 101 cycles, each ch0 ∈ {9,10}; drop Enable mid-gate → that gate still completes, one more Valid, then Busy=0.
- Rst_n low at cycle 50 of a gate → all outputs 0 immediately; no Valid for that gate; after release with Enable=1 a fresh full gate yields ch0 = 10.
- Change Gate_Sel 0→2 mid-gate → current gate lasts 100 cycles; following gate lasts 10000.
